// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C slave: master writes set ptr then fill regs, master reads stream reg[ptr].
// Latency: bus write lands 1 cycle after rx_valid; tx_load 2 cycles after tx_ready; usr_rdata 1 cycle.
// Backpressure: tx side waits on tx_ready (slave PISO empty); rx side never stalls the slave.
module i2c_reg_bank #(
    parameter int NREGS = 16,
    localparam int AW = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          rx_active,
    input  logic          tx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_load,
    input  logic [AW-1:0] usr_addr,
    input  logic          usr_we,
    input  logic [7:0]    usr_wdata,
    output logic [7:0]    usr_rdata,
    output logic          bus_wr,
    output logic [AW-1:0] bus_wr_addr
);

    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_PTR  = 2'd1;
    localparam logic [1:0] RX_DATA = 2'd2;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_LOAD = 2'd1;
    localparam logic [1:0] TX_BUSY = 2'd2;
    localparam logic [1:0] TX_SENT = 2'd3;

    logic [7:0]    regs [NREGS];
    logic [AW-1:0] ptr;
    logic [1:0]    rx_state;
    logic [1:0]    tx_state;
    logic          rx_active_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            ptr         <= '0;
            rx_state    <= RX_IDLE;
            tx_state    <= TX_IDLE;
            rx_active_q <= 1'b0;
            tx_data     <= '0;
            tx_load     <= 1'b0;
            usr_rdata   <= '0;
            bus_wr      <= 1'b0;
            bus_wr_addr <= '0;
        end else begin
            rx_active_q <= rx_active;
            bus_wr      <= 1'b0;
            tx_load     <= 1'b0;
            usr_rdata   <= regs[usr_addr];
            if (usr_we) regs[usr_addr] <= usr_wdata;

            // A master write kills any read in flight; the prefetched byte is simply dropped.
            if (rx_active) begin
                tx_state <= TX_IDLE;
            end else begin
                case (tx_state)
                    TX_IDLE: if (tx_ready) tx_state <= TX_LOAD;
                    TX_LOAD: begin
                        tx_data  <= regs[ptr];
                        tx_load  <= 1'b1;
                        tx_state <= TX_BUSY;
                    end
                    TX_BUSY: if (!tx_ready) tx_state <= TX_SENT;
                    TX_SENT: if (tx_ready) begin
                        ptr      <= ptr + AW'(1);
                        tx_state <= TX_LOAD;
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end

            // Placed after the tx logic so the bus write owns regs/ptr on any overlap.
            case (rx_state)
                RX_IDLE: if (rx_active && !rx_active_q) rx_state <= RX_PTR;
                RX_PTR: begin
                    if (rx_valid) begin
                        ptr      <= rx_data[AW-1:0];
                        rx_state <= RX_DATA;
                    end
                    if (!rx_active) rx_state <= RX_IDLE;
                end
                RX_DATA: begin
                    if (rx_valid) begin
                        regs[ptr]   <= rx_data;
                        ptr         <= ptr + AW'(1);
                        bus_wr      <= 1'b1;
                        bus_wr_addr <= ptr;
                    end
                    if (!rx_active) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank (NREGS=16): reset, bus writes, wrap, reads, abort, collisions.
module tb_i2c_reg_bank;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [3:0] usr_addr;
    logic       usr_we;
    logic [7:0] usr_wdata;
    logic [7:0] usr_rdata;
    logic       bus_wr;
    logic [3:0] bus_wr_addr;

    int errors = 0;
    int checks = 0;

    i2c_reg_bank #(.NREGS(16)) dut (
        .clock(clock), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_load(tx_load),
        .usr_addr(usr_addr), .usr_we(usr_we), .usr_wdata(usr_wdata),
        .usr_rdata(usr_rdata), .bus_wr(bus_wr), .bus_wr_addr(bus_wr_addr)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input logic [3:0] a, input logic [7:0] exp, input string tag);
        usr_addr = a;
        usr_we   = 1'b0;
        tick();
        chk(tag, usr_rdata, exp);
    endtask

    task automatic usr_write(input logic [3:0] a, input logic [7:0] d);
        usr_addr  = a;
        usr_wdata = d;
        usr_we    = 1'b1;
        tick();
        usr_we    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_wr,
                             input logic [3:0] exp_addr, input string tag);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk({tag, "_wr"}, bus_wr, exp_wr);
        if (exp_wr) chk({tag, "_addr"}, bus_wr_addr, exp_addr);
        tick();
        chk({tag, "_wr_done"}, bus_wr, 1'b0);
    endtask

    task automatic wait_load(input logic [7:0] exp, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = tx_load;
        end
        chk({tag, "_load_seen"}, seen, 1'b1);
        if (seen) begin
            chk({tag, "_data"}, tx_data, exp);
            tick();
            chk({tag, "_load_1cyc"}, tx_load, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; rx_data = 8'h5A; rx_valid = 1'b0; rx_active = 1'b1;
        tx_ready = 1'b0; usr_addr = '0; usr_we = 1'b0; usr_wdata = '0;

        // Reset with rx_valid toggling
        rx_valid = 1'b1; tick();
        rx_valid = 1'b0; tick();
        rx_valid = 1'b1;
        reset = 1'b0; rx_valid = 1'b0; rx_active = 1'b0;
        chk("rst_tx_load", tx_load, 1'b0);
        chk("rst_bus_wr", bus_wr, 1'b0);
        chk("rst_bus_wr_addr", bus_wr_addr, 4'h0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_usr_rdata", usr_rdata, 8'h00);
        for (int i = 0; i < 16; i++) read_reg(4'(i), 8'h00, "rst_reg");

        // Basic write: ptr 3, then 0xAA, 0xBB
        rx_active = 1'b1; tick();
        send_byte(8'h03, 1'b0, 4'h0, "wr_ptr");
        send_byte(8'hAA, 1'b1, 4'h3, "wr_b0");
        send_byte(8'hBB, 1'b1, 4'h4, "wr_b1");
        rx_active = 1'b0; tick();
        read_reg(4'h3, 8'hAA, "wr_reg3");
        read_reg(4'h4, 8'hBB, "wr_reg4");

        // Pointer wrap from 15
        rx_active = 1'b1; tick();
        send_byte(8'h0F, 1'b0, 4'h0, "wrap_ptr");
        send_byte(8'h01, 1'b1, 4'hF, "wrap_b0");
        send_byte(8'h02, 1'b1, 4'h0, "wrap_b1");
        send_byte(8'h03, 1'b1, 4'h1, "wrap_b2");
        rx_active = 1'b0; tick();
        read_reg(4'hF, 8'h01, "wrap_reg15");
        read_reg(4'h0, 8'h02, "wrap_reg0");
        read_reg(4'h1, 8'h03, "wrap_reg1");

        // Pointer upper bits ignored; last byte arrives with the fall of rx_active
        rx_active = 1'b1; tick();
        send_byte(8'h23, 1'b0, 4'h0, "ptr23");
        rx_data = 8'h77; rx_valid = 1'b1; rx_active = 1'b0;
        tick();
        rx_valid = 1'b0;
        chk("fall_byte_wr", bus_wr, 1'b1);
        chk("fall_byte_addr", bus_wr_addr, 4'h3);
        tick();
        read_reg(4'h3, 8'h77, "fall_byte_reg3");

        // Master read from ptr 5
        usr_write(4'h5, 8'h5C);
        usr_write(4'h6, 8'h6D);
        usr_write(4'h2, 8'h2E);
        rx_active = 1'b1; tick();
        send_byte(8'h05, 1'b0, 4'h0, "rd_ptr");
        rx_active = 1'b0; tick();
        tx_ready = 1'b1;
        wait_load(8'h5C, "rd0");
        tx_ready = 1'b0; tick(); tick();
        chk("rd_busy_no_load", tx_load, 1'b0);
        tx_ready = 1'b1;
        wait_load(8'h6D, "rd1");

        // Abort: prefetch reg2, then a master write starts before shifting
        rx_active = 1'b1; tick();
        send_byte(8'h02, 1'b0, 4'h0, "ab_ptr");
        rx_active = 1'b0;
        wait_load(8'h2E, "ab_pre");
        rx_active = 1'b1; tick(); tick();
        chk("ab_no_load", tx_load, 1'b0);
        rx_active = 1'b0;
        wait_load(8'h2E, "ab_ptr_kept");
        tx_ready = 1'b0;

        // Same-address collision: bus wins; different addresses both land
        rx_active = 1'b1; tick();
        send_byte(8'h07, 1'b0, 4'h0, "col_ptr");
        rx_data = 8'h11; rx_valid = 1'b1;
        usr_addr = 4'h7; usr_wdata = 8'h22; usr_we = 1'b1;
        tick();
        chk("col_wr_addr", bus_wr_addr, 4'h7);
        rx_data = 8'h88; usr_addr = 4'h9; usr_wdata = 8'h99;
        tick();
        chk("col2_wr_addr", bus_wr_addr, 4'h8);
        rx_valid = 1'b0; usr_we = 1'b0; rx_active = 1'b0;
        tick();
        read_reg(4'h7, 8'h11, "col_reg7");
        read_reg(4'h8, 8'h88, "col_reg8");
        read_reg(4'h9, 8'h99, "col_reg9");

        // Read in the cycle of a write returns the old value
        usr_addr = 4'h9; usr_wdata = 8'h5A; usr_we = 1'b1;
        tick();
        usr_we = 1'b0;
        chk("rdw_old", usr_rdata, 8'h99);
        tick();
        chk("rdw_new", usr_rdata, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
